// File: rtl/fifo_sc_param.sv
// Single-clock FIFO with parameterised depth, programmable almost-full/empty levels and optional show-ahead read.
// Latency: write visible next cycle; q is 1 cycle after rdreq (normal) or 0 cycles (show-ahead).
// Backpressure: writes while full and reads while empty are dropped and latched into sticky overflow/underflow.
module fifo_sc_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter int SHOWAHEAD  = 0
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  sclr,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] usedw_q, usedw_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc;
  logic          rd_acc;

  // Flags decode straight from the registered count so they move on the accepting edge.
  assign empty        = (usedw_q == '0);
  assign full         = (usedw_q == DEPTH_C);
  assign almost_full  = (usedw_q >= AF_C);
  assign almost_empty = (usedw_q <  AE_C);
  assign usedw        = usedw_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_acc = wrreq & ~full;
  assign rd_acc = rdreq & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = ovf_q | (wrreq & full);
    udf_d    = udf_q | (rdreq & empty);
    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   usedw_d = usedw_q + CW'(1);
        2'b01:   usedw_d = usedw_q - CW'(1);
        default: usedw_d = usedw_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage has no reset; aclr_n gating keeps an edge during reset from landing a write.
  always_ff @(posedge clock) begin
    if (aclr_n && !sclr && wr_acc) begin
      mem[wr_ptr_q] <= data;
    end
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    assign q = empty ? '0 : mem[rd_ptr_q];
  end else begin : g_normal
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
      q_d = q_q;
      if (sclr)        q_d = '0;
      else if (rd_acc) q_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) q_q <= '0;
      else         q_q <= q_d;
    end

    assign q = q_q;
  end

endmodule

// File: tb/tb_fifo_sc_param.sv
// Bench for fifo_sc_param: one normal-mode and one show-ahead instance, scoreboard-checked.
module tb_fifo_sc_param;

  logic       clock = 1'b0;
  logic       aclr_n;
  logic       sclr, wrreq, rdreq;
  logic [7:0] data;
  logic [7:0] q;
  logic       empty, full, almost_full, almost_empty, overflow, underflow;
  logic [4:0] usedw;

  logic       sclr_s, wrreq_s, rdreq_s;
  logic [7:0] data_s;
  logic [7:0] q_s;
  logic       empty_s, full_s, af_s, ae_s, ovf_s, udf_s;
  logic [4:0] usedw_s;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] sb[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  always #5 clock = ~clock;

  fifo_sc_param #(.WIDTH(8), .DEPTH_LOG2(4), .AF_LEVEL(12), .AE_LEVEL(4), .SHOWAHEAD(0)) u_n (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .usedw(usedw), .overflow(overflow), .underflow(underflow)
  );

  fifo_sc_param #(.WIDTH(8), .DEPTH_LOG2(4), .AF_LEVEL(12), .AE_LEVEL(4), .SHOWAHEAD(1)) u_s (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr_s), .data(data_s), .wrreq(wrreq_s), .rdreq(rdreq_s),
    .q(q_s), .empty(empty_s), .full(full_s), .almost_full(af_s), .almost_empty(ae_s),
    .usedw(usedw_s), .overflow(ovf_s), .underflow(udf_s)
  );

  // Drives one cycle on the normal instance and advances the reference model.
  task automatic cyc(input logic wr, input logic rd, input logic [7:0] d,
                     output logic rd_ok, output logic [7:0] exp_q);
    logic w_ok;
    w_ok  = wr && (m_cnt != 16);
    rd_ok = rd && (m_cnt != 0);
    exp_q = 8'h00;
    if (wr && m_cnt == 16) m_ovf = 1'b1;
    if (rd && m_cnt == 0)  m_udf = 1'b1;
    if (rd_ok) exp_q = sb.pop_front();
    if (w_ok)  sb.push_back(d);
    wrreq = wr; rdreq = rd; data = d;
    @(posedge clock); #1;
    wrreq = 1'b0; rdreq = 1'b0;
    m_cnt = m_cnt + (w_ok ? 1 : 0) - (rd_ok ? 1 : 0);
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
    sclr_s = 1'b0; wrreq_s = 1'b0; rdreq_s = 1'b0; data_s = 8'h00;
    #2;
    n_chk++; if (usedw !== 5'd0) $display("FAIL rst_usedw got %0d exp 0", usedw); else n_pass++;
    n_chk++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_empty_full got %b%b exp 10", empty, full); else n_pass++;
    n_chk++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) $display("FAIL rst_ae_af got %b%b exp 10", almost_empty, almost_full); else n_pass++;
    n_chk++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL rst_ovf_udf got %b%b exp 00", overflow, underflow); else n_pass++;
    n_chk++; if (q !== 8'h00 || q_s !== 8'h00) $display("FAIL rst_q got %h/%h exp 00/00", q, q_s); else n_pass++;
    @(posedge clock); #2;
    aclr_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic ok; logic [7:0] e;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i), ok, e);
      n_chk++; if (usedw !== 5'(m_cnt)) $display("FAIL fill_usedw got %0d exp %0d", usedw, m_cnt); else n_pass++;
      n_chk++; if (almost_full !== (m_cnt >= 12)) $display("FAIL fill_af got %b at usedw %0d", almost_full, m_cnt); else n_pass++;
    end
    n_chk++; if (full !== 1'b1 || usedw !== 5'd16) $display("FAIL fill_full got full=%b usedw=%0d exp 1/16", full, usedw); else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00, ok, e);
      n_chk++; if (!ok || q !== e) $display("FAIL drain_q got %h exp %h", q, e); else n_pass++;
      n_chk++; if (almost_empty !== (m_cnt < 4)) $display("FAIL drain_ae got %b at usedw %0d", almost_empty, m_cnt); else n_pass++;
    end
    n_chk++; if (empty !== 1'b1 || usedw !== 5'd0) $display("FAIL drain_empty got %b/%0d exp 1/0", empty, usedw); else n_pass++;
  endtask

  task automatic test_overflow_sclr();
    logic ok; logic [7:0] e;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h21 + 8'(i), ok, e);
    cyc(1'b1, 1'b1, 8'hEE, ok, e);
    n_chk++; if (usedw !== 5'd15) $display("FAIL ovf_usedw got %0d exp 15", usedw); else n_pass++;
    n_chk++; if (overflow !== m_ovf) $display("FAIL ovf_flag got %b exp %b", overflow, m_ovf); else n_pass++;
    n_chk++; if (q !== e) $display("FAIL ovf_read_q got %h exp %h", q, e); else n_pass++;
    sclr = 1'b1; @(posedge clock); #1; sclr = 1'b0;
    sb.delete(); m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
    n_chk++; if (usedw !== 5'd0 || empty !== 1'b1) $display("FAIL sclr_usedw_empty got %0d/%b exp 0/1", usedw, empty); else n_pass++;
    n_chk++; if (overflow !== 1'b0 || q !== 8'h00) $display("FAIL sclr_ovf_q got %b/%h exp 0/00", overflow, q); else n_pass++;
  endtask

  task automatic test_underflow_steady();
    logic ok; logic [7:0] e; logic [7:0] last;
    cyc(1'b1, 1'b0, 8'h77, ok, e);
    cyc(1'b0, 1'b1, 8'h00, ok, e);
    last = e;
    n_chk++; if (q !== 8'h77) $display("FAIL pre_udf_q got %h exp 77", q); else n_pass++;
    cyc(1'b0, 1'b1, 8'h00, ok, e);
    n_chk++; if (underflow !== m_udf || underflow !== 1'b1) $display("FAIL udf_flag got %b exp 1", underflow); else n_pass++;
    n_chk++; if (usedw !== 5'd0 || q !== last) $display("FAIL udf_hold got usedw=%0d q=%h exp 0/%h", usedw, q, last); else n_pass++;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i), ok, e);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 8'h50 + 8'(i), ok, e);
      n_chk++; if (!ok || q !== e) $display("FAIL steady_q got %h exp %h", q, e); else n_pass++;
      n_chk++; if (usedw !== 5'd5) $display("FAIL steady_usedw got %0d exp 5", usedw); else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 8'h00, ok, e);
      n_chk++; if (q !== e) $display("FAIL steady_drain_q got %h exp %h", q, e); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic ok; logic [7:0] e;
    logic [7:0] pat;
    pat = 8'h80;
    for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0, pat, ok, e); pat++; end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, (i % 4) != 0, pat, ok, e);
      pat++;
      if (ok) begin
        n_chk++; if (q !== e) $display("FAIL wrap_q got %h exp %h", q, e); else n_pass++;
      end
      n_chk++; if (empty !== (m_cnt == 0) || full !== (m_cnt == 16)) $display("FAIL wrap_flags got e=%b f=%b at usedw %0d", empty, full, m_cnt); else n_pass++;
    end
    while (m_cnt > 0) begin
      cyc(1'b0, 1'b1, 8'h00, ok, e);
      n_chk++; if (q !== e) $display("FAIL wrap_drain_q got %h exp %h", q, e); else n_pass++;
    end
  endtask

  task automatic test_showahead();
    n_chk++; if (q_s !== 8'h00 || empty_s !== 1'b1) $display("FAIL sa_idle got q=%h e=%b exp 00/1", q_s, empty_s); else n_pass++;
    wrreq_s = 1'b1; data_s = 8'hA5; @(posedge clock); #1; wrreq_s = 1'b0;
    n_chk++; if (empty_s !== 1'b0 || q_s !== 8'hA5) $display("FAIL sa_head got q=%h e=%b exp A5/0", q_s, empty_s); else n_pass++;
    rdreq_s = 1'b1; @(posedge clock); #1; rdreq_s = 1'b0;
    n_chk++; if (empty_s !== 1'b1 || q_s !== 8'h00) $display("FAIL sa_read got q=%h e=%b exp 00/1", q_s, empty_s); else n_pass++;
    wrreq_s = 1'b1; data_s = 8'hB1; @(posedge clock); #1; data_s = 8'hB2; @(posedge clock); #1; wrreq_s = 1'b0;
    n_chk++; if (q_s !== 8'hB1) $display("FAIL sa_first got %h exp B1", q_s); else n_pass++;
    rdreq_s = 1'b1; @(posedge clock); #1; rdreq_s = 1'b0;
    n_chk++; if (q_s !== 8'hB2 || usedw_s !== 5'd1) $display("FAIL sa_next got %h/%0d exp B2/1", q_s, usedw_s); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic ok; logic [7:0] e;
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'h60 + 8'(i), ok, e);
    cyc(1'b0, 1'b1, 8'h00, ok, e);
    cyc(1'b1, 1'b0, 8'h69, ok, e);
    n_chk++; if (usedw !== 5'd9 || q !== 8'h60) $display("FAIL pre_arst got usedw=%0d q=%h exp 9/60", usedw, q); else n_pass++;
    #3; aclr_n = 1'b0; #1;
    sb.delete(); m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
    n_chk++; if (usedw !== 5'd0 || q !== 8'h00) $display("FAIL arst_usedw_q got %0d/%h exp 0/00", usedw, q); else n_pass++;
    n_chk++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || almost_empty !== 1'b1) $display("FAIL arst_flags got e=%b f=%b af=%b ae=%b", empty, full, almost_full, almost_empty); else n_pass++;
    n_chk++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL arst_sticky got %b%b exp 00", overflow, underflow); else n_pass++;
    wrreq = 1'b1; data = 8'h99; @(posedge clock); #1; wrreq = 1'b0;
    n_chk++; if (usedw !== 5'd0 || empty !== 1'b1) $display("FAIL arst_abort got usedw=%0d e=%b exp 0/1", usedw, empty); else n_pass++;
    #3; aclr_n = 1'b1;
    cyc(1'b1, 1'b0, 8'h3C, ok, e);
    n_chk++; if (empty !== 1'b0 || usedw !== 5'd1) $display("FAIL post_arst_wr got e=%b usedw=%0d exp 0/1", empty, usedw); else n_pass++;
    cyc(1'b0, 1'b1, 8'h00, ok, e);
    n_chk++; if (q !== 8'h3C || e !== 8'h3C) $display("FAIL post_arst_q got %h exp 3C", q); else n_pass++;
    n_chk++; if (empty !== 1'b1) $display("FAIL post_arst_empty got %b exp 1", empty); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_sclr();
    test_underflow_steady();
    test_wrap();
    test_showahead();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
